// File: rtl/ben_cc_unit.sv
// LC-3 condition-code register, branch-enable latch and saved-NZP LIFO.
// BEN optionally sees the NZP being written in the same cycle (BYPASS_EN).
module ben_cc_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4,
    parameter bit BYPASS_EN   = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  LD_CC,
    input  logic [DATA_WIDTH-1:0] BUS,
    input  logic                  LD_BEN,
    input  logic [2:0]            IR_11_9,
    input  logic                  CC_PUSH,
    input  logic                  CC_POP,
    output logic [2:0]            NZP,
    output logic                  BEN,
    output logic                  STACK_EMPTY,
    output logic                  STACK_FULL,
    output logic                  STACK_ERR
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [2:0]    stack_mem [STACK_DEPTH];
    logic [CW-1:0] count;
    logic          empty, full;
    logic          push_ok, pop_ok, err_event;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          n_bit, z_bit;
    logic [2:0]    nzp_gen, nzp_next, ben_src;

    assign empty  = (count == '0);
    assign full   = (count == CW'(STACK_DEPTH));
    assign wr_idx = IW'(count);
    assign rd_idx = IW'(count - CW'(1));

    // Simultaneous push and pop cancel each other and count as an error.
    assign push_ok   = CC_PUSH & ~CC_POP & ~full;
    assign pop_ok    = CC_POP & ~CC_PUSH & ~empty;
    assign err_event = (CC_PUSH & CC_POP) | (CC_PUSH & ~CC_POP & full) |
                       (CC_POP & ~CC_PUSH & empty);

    assign n_bit   = BUS[DATA_WIDTH-1];
    assign z_bit   = (BUS == '0);
    assign nzp_gen = {n_bit, z_bit, ~n_bit & ~z_bit};

    always_comb begin
        nzp_next = NZP;
        if (pop_ok) begin
            nzp_next = stack_mem[rd_idx];
        end else if (LD_CC) begin
            nzp_next = nzp_gen;
        end
    end

    always_comb begin
        ben_src = NZP;
        if (BYPASS_EN && LD_CC) begin
            ben_src = nzp_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            NZP       <= 3'b010;
            BEN       <= 1'b0;
            count     <= '0;
            STACK_ERR <= 1'b0;
        end else begin
            NZP <= nzp_next;
            if (LD_BEN) begin
                BEN <= |(IR_11_9 & ben_src);
            end
            if (push_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok) begin
                count <= count - CW'(1);
            end
            if (err_event) begin
                STACK_ERR <= 1'b1;
            end
        end
    end

    // Stack contents need no reset; only count decides what is valid.
    always_ff @(posedge Clk) begin
        if (!Reset && push_ok) begin
            stack_mem[wr_idx] <= NZP;
        end
    end

    assign STACK_EMPTY = empty;
    assign STACK_FULL  = full;

endmodule

// File: tb/tb_ben_cc_unit.sv
// Scoreboard bench for ben_cc_unit: one instance without and one with bypass.
module tb_ben_cc_unit;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset, LD_CC, LD_BEN, CC_PUSH, CC_POP;
    logic [15:0] BUS;
    logic [2:0]  IR_11_9;
    logic [2:0]  nzp0, nzp1;
    logic        ben0, ben1, empty0, empty1, full0, full1, err0, err1;

    always #5 Clk = ~Clk;

    ben_cc_unit #(.DATA_WIDTH(16), .STACK_DEPTH(DEPTH), .BYPASS_EN(1'b0)) dut0 (
        .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .BUS(BUS), .LD_BEN(LD_BEN),
        .IR_11_9(IR_11_9), .CC_PUSH(CC_PUSH), .CC_POP(CC_POP), .NZP(nzp0),
        .BEN(ben0), .STACK_EMPTY(empty0), .STACK_FULL(full0), .STACK_ERR(err0));

    ben_cc_unit #(.DATA_WIDTH(16), .STACK_DEPTH(DEPTH), .BYPASS_EN(1'b1)) dut1 (
        .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .BUS(BUS), .LD_BEN(LD_BEN),
        .IR_11_9(IR_11_9), .CC_PUSH(CC_PUSH), .CC_POP(CC_POP), .NZP(nzp1),
        .BEN(ben1), .STACK_EMPTY(empty1), .STACK_FULL(full1), .STACK_ERR(err1));

    typedef struct {
        logic [2:0] nzp;
        logic       ben0, ben1, empty, full, err;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] m_stk[$];
    logic [2:0] m_nzp;
    logic       m_ben0, m_ben1, m_err;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic lcc, input logic [15:0] b,
                        input logic lben, input logic [2:0] ir,
                        input logic psh, input logic pp);
        exp_t       e, o;
        logic [2:0] gen, nxt;
        logic       push_ok, pop_ok;
        @(negedge Clk);
        Reset = rst; LD_CC = lcc; BUS = b; LD_BEN = lben; IR_11_9 = ir;
        CC_PUSH = psh; CC_POP = pp;
        if (b[15])         gen = 3'b100;
        else if (b == 0)   gen = 3'b010;
        else               gen = 3'b001;
        if (rst) begin
            m_nzp = 3'b010; m_ben0 = 1'b0; m_ben1 = 1'b0; m_err = 1'b0;
            m_stk.delete();
        end else begin
            push_ok = psh && !pp && (m_stk.size() < DEPTH);
            pop_ok  = pp && !psh && (m_stk.size() > 0);
            if ((psh && pp) || (psh && !pp && !push_ok) || (pp && !psh && !pop_ok))
                m_err = 1'b1;
            nxt = pop_ok ? m_stk[$] : (lcc ? gen : m_nzp);
            if (lben) begin
                m_ben0 = |(ir & m_nzp);
                m_ben1 = |(ir & (lcc ? nxt : m_nzp));
            end
            if (push_ok) m_stk.push_back(m_nzp);
            if (pop_ok)  void'(m_stk.pop_back());
            m_nzp = nxt;
        end
        e.nzp = m_nzp; e.ben0 = m_ben0; e.ben1 = m_ben1; e.err = m_err;
        e.empty = (m_stk.size() == 0); e.full = (m_stk.size() == DEPTH);
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underrun", 32'd0, 32'd1);
        end else begin
            o = sb.pop_front();
            chk("nzp0",  {29'd0, nzp0}, {29'd0, o.nzp});
            chk("nzp1",  {29'd0, nzp1}, {29'd0, o.nzp});
            chk("ben0",  {31'd0, ben0}, {31'd0, o.ben0});
            chk("ben1",  {31'd0, ben1}, {31'd0, o.ben1});
            chk("empty", {30'd0, empty1, empty0}, {30'd0, o.empty, o.empty});
            chk("full",  {30'd0, full1, full0},   {30'd0, o.full, o.full});
            chk("err",   {30'd0, err1, err0},     {30'd0, o.err, o.err});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; LD_CC = 1'b0; BUS = '0; LD_BEN = 1'b0; IR_11_9 = '0;
        CC_PUSH = 1'b0; CC_POP = 1'b0;
        m_nzp = 3'b010; m_ben0 = 1'b0; m_ben1 = 1'b0; m_err = 1'b0;

        step(1'b1, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        chk("rst_nzp", {29'd0, nzp0}, 32'd2);
        chk("rst_ben", {31'd0, ben0}, 32'd0);
        chk("rst_flags", {29'd0, empty0, full0, err0}, 32'b100);

        step(1'b0, 1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b0);
        chk("cc_neg", {29'd0, nzp0}, 32'b100);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0);
        chk("cc_zero", {29'd0, nzp0}, 32'b010);
        step(1'b0, 1'b1, 16'h0001, 1'b0, 3'b000, 1'b0, 1'b0);
        chk("cc_pos", {29'd0, nzp0}, 32'b001);

        step(1'b0, 1'b0, 16'h0, 1'b1, 3'b001, 1'b0, 1'b0);
        chk("ben_p", {31'd0, ben0}, 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 3'b110, 1'b0, 1'b0);
        chk("ben_nz", {31'd0, ben0}, 32'd0);
        idle(); idle(); idle();
        chk("ben_hold", {31'd0, ben0}, 32'd0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 3'b111, 1'b0, 1'b0);
        chk("ben_111", {31'd0, ben0}, 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 3'b000, 1'b0, 1'b0);
        chk("ben_000", {31'd0, ben0}, 32'd0);

        step(1'b0, 1'b1, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b1, 3'b100, 1'b0, 1'b0);
        chk("byp0_ben", {31'd0, ben0}, 32'd0);
        chk("byp1_ben", {31'd0, ben1}, 32'd1);
        chk("byp_nzp", {26'd0, nzp1, nzp0}, {26'd0, 3'b100, 3'b100});

        step(1'b0, 1'b1, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0001, 1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h8000, 1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b1, 1'b0);
        chk("full4", {30'd0, full0, err0}, 32'b10);
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b1, 1'b0);
        chk("ovf", {30'd0, full0, err0}, 32'b11);

        step(1'b0, 1'b1, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b1);
        chk("pop1", {29'd0, nzp0}, 32'b100);
        step(1'b0, 1'b1, 16'h0000, 1'b1, 3'b001, 1'b0, 1'b1);
        chk("pop2", {29'd0, nzp0}, 32'b001);
        chk("pop_byp", {30'd0, ben1, ben0}, 32'b10);
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        chk("pop3", {29'd0, nzp0}, 32'b010);
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        chk("pop4", {30'd0, nzp0[2], empty0}, 32'b11);

        step(1'b1, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 3'b000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b1);
        chk("unf", {28'd0, nzp0, err0}, {28'd0, 3'b010, 1'b1});
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b1, 1'b1);
        chk("pushpop", {30'd0, empty0, full0}, 32'b00);
        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b0, 1'b1);
        chk("pp_pop", {28'd0, nzp0, empty0}, {28'd0, 3'b010, 1'b1});

        step(1'b0, 1'b0, 16'h0, 1'b0, 3'b000, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 3'b111, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h8000, 1'b1, 3'b111, 1'b1, 1'b0);
        chk("midrst", {26'd0, nzp0, ben0, empty0, full0, err0}, {26'd0, 3'b010, 4'b0100});

        for (int i = 0; i < 300; i++) begin
            logic [15:0] b;
            case ($urandom_range(0, 3))
                0:       b = 16'h0000;
                1:       b = 16'h8000 | 16'($urandom);
                default: b = 16'($urandom);
            endcase
            step(($urandom_range(0, 63) == 0), 1'($urandom), b, 1'($urandom),
                 3'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ben_cc_unit.md
# ben_cc_unit

Parametrised condition-code and branch-enable unit for the LC-3 datapath. It derives the N/Z/P condition codes from the data bus, holds them in a register, and latches the branch-enable bit (BEN) from IR[11:9]. A small LIFO of saved condition codes supports interrupt entry and RTI. An optional bypass lets a branch use condition codes written in the same cycle. The block sits between the bus, the IR and the control FSM, and replaces the separate NZP register and BEN flop.

## Interface
- DATA_WIDTH, 16: width of the bus sampled for condition codes (min 2).
- STACK_DEPTH, 4: number of saved NZP entries (min 1).
- BYPASS_EN, 0: 1 = BEN computed from next-cycle NZP when LD_CC and LD_BEN are asserted together; 0 = always from the registered NZP.

Ports:
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- LD_CC  in  1  load NZP from BUS.
- BUS  in  DATA_WIDTH  datapath bus value.
- LD_BEN  in  1  latch BEN.
- IR_11_9  in  3  branch condition mask {n,z,p}.
- CC_PUSH  in  1  save current NZP onto the stack (interrupt entry).
- CC_POP  in  1  restore NZP from the stack (RTI).
- NZP  out  3  registered condition codes {N,Z,P}.
- BEN  out  1  registered branch enable.
- STACK_EMPTY  out  1  stack holds 0 entries.
- STACK_FULL  out  1  stack holds STACK_DEPTH entries.
- STACK_ERR  out  1  sticky flag: overflow, underflow or conflicting push/pop.

## Operation
- NZP generation from BUS:
  - N = BUS[DATA_WIDTH-1].
  - Z = (BUS == 0).
  - P = !N & !Z.
  - The result is always one-hot.
- NZP next-state, in priority order:
  1. Reset → 3'b010.
  2. Valid pop → top stack entry.
  3. LD_CC → generated value.
  4. Otherwise hold.
- LD_CC together with a valid pop: the pop wins and the LD_CC is discarded.
- Push: writes the current registered NZP (pre-update value) to the top of the stack, then increments the count.
  - LD_CC in the same cycle is legal: the old NZP is pushed and the new value is loaded.
- Pop: decrements the count and loads the entry into NZP.
- Stack is a LIFO with count 0..STACK_DEPTH. STACK_EMPTY = (count==0); STACK_FULL = (count==STACK_DEPTH).
- Push when full: ignored, no state change, STACK_ERR set.
- Pop when empty: ignored, NZP unaffected (LD_CC applies normally), STACK_ERR set.
- CC_PUSH and CC_POP in the same cycle: both ignored, STACK_ERR set. LD_CC still applies.
- STACK_ERR clears only on Reset.
- BEN:
  - On LD_BEN: BEN <= |(IR_11_9 & src), otherwise BEN holds.
  - src = registered NZP, except when BYPASS_EN=1 and LD_CC=1, in which case src = the NZP next-state value (including pop priority).
  - IR_11_9 = 3'b000 → BEN=0. IR_11_9 = 3'b111 → BEN=1 (NZP is never 000 after reset).

## Timing
- Reset values:
  - NZP = 3'b010, BEN = 0.
  - count = 0, STACK_EMPTY = 1, STACK_FULL = 0, STACK_ERR = 0.
  - Stack contents are don't-care.
- Reset asserted mid-operation (any command active) overrides everything in that cycle.
- LD_CC → NZP valid 1 cycle after the edge.
- LD_BEN → BEN valid 1 cycle after the edge.
- With BYPASS_EN=0, a branch must assert LD_BEN at least 1 cycle after LD_CC to see the new codes.
- Push/pop → count, flags and NZP update on the same edge. Back-to-back push/pop on consecutive cycles is supported at full rate.
- All outputs come directly from flops; there is no combinational input-to-output path.

## Test plan
- Reset, then LD_CC with BUS=16'h8000, 16'h0000 and 16'h0001 on consecutive cycles → NZP = 100, 010, 001.
- NZP=001, LD_BEN with IR_11_9=001 → BEN=1. Then IR_11_9=110 → BEN=0. Then LD_BEN=0 for 3 cycles → BEN holds 0.
- BYPASS_EN=0 vs BYPASS_EN=1, with NZP=010, LD_CC(BUS=16'hFFFF) and LD_BEN(IR=100) in the same cycle → BEN=0 when BYPASS_EN=0, BEN=1 when BYPASS_EN=1. NZP=100 in both cases.
- STACK_DEPTH=4:
  - Push 4 times with NZP 100/010/001/100 → STACK_FULL=1.
  - A 5th push → STACK_ERR=1, count stays 4.
  - 4 pops → NZP = 100, 001, 010, 100, then STACK_EMPTY=1.
- Pop when empty together with LD_CC(BUS=0) → NZP=010, STACK_ERR=1. Then push+pop together → count unchanged.
- Reset asserted with stack count 2, STACK_ERR=1 and LD_CC active → all outputs return to reset values next cycle.
